axi_io_arbiter: RTL
===================

Name: axi_io_arbiter

Overview:
- Shares the single request-level AXI master (the UART-lite port) between two requesters.
  - Port 0: the boot/IO sequencer, used for program load and result dump.
  - Port 1: the core's runtime I/O unit, used for stdin reads and stdout writes.
- Sits between the requesters and axi_master.
- Grants one transaction at a time, round-robin.
- Issues a one-cycle start strobe to the master and routes the completion pulse back to the granted requester only.
- Adds a write watchdog so a hung B channel cannot lock the port.

Parameters:
- AXI_ADDRW, 4, address width forwarded to axi_master.
- AXI_DATAW, 32, data width forwarded to axi_master.
- WDOG_W, 16, width of the write watchdog counter.
- WDOG_LIMIT, 16'hFFFF, number of cycles spent in WAIT_W before a write is declared timed out.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Asynchronous, active-low reset.
- s_re  in  2  Per-requester read request; level, index = requester.
- s_we  in  2  Per-requester write request; level.
- s_addr  in  2*AXI_ADDRW  Per-requester address; slice i belongs to requester i.
- s_wdata  in  2*AXI_DATAW  Per-requester write data.
- s_wstrb  in  2*(AXI_DATAW/8)  Per-requester write strobes.
- s_rdata  out  AXI_DATAW  Shared read data; valid while the corresponding s_r_success bit is high.
- s_r_success  out  2  Per-requester read-done pulse.
- s_r_timeout  out  2  Per-requester read-timeout pulse.
- s_w_success  out  2  Per-requester write-done pulse.
- s_w_timeout  out  2  Per-requester write-watchdog pulse.
- grant  out  1  Index of the current or last granted requester.
- busy  out  1  High in any state except IDLE.
- m_re  out  1  Read start strobe to axi_master.
- m_we  out  1  Write start strobe to axi_master.
- m_araddr  out  AXI_ADDRW  Read address to axi_master.
- m_awaddr  out  AXI_ADDRW  Write address to axi_master.
- m_wdata  out  AXI_DATAW  Write data to axi_master.
- m_wstrb  out  AXI_DATAW/8  Write strobes to axi_master.
- m_rdata  in  AXI_DATAW  Read data from axi_master.
- m_r_success  in  1  Read completed.
- m_r_timeout  in  1  Read timed out.
- m_w_success  in  1  Write completed.
- m_w_busy  in  1  Master cannot accept a write start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, busy=0.
  - All strobe and pulse outputs are 0.
  - m_*addr, m_wdata, m_wstrb and s_rdata are 0; watchdog=0.
  - Reset mid-transaction abandons that transaction without reporting it. The requester and axi_master share this reset.
- All outputs are registered.
- Requester contract:
  - Raise s_re[i] or s_we[i] and hold it, with s_addr, s_wdata and s_wstrb stable, until a done pulse for i arrives.
  - Drop the request in the cycle after the pulse.
- FSM states: IDLE, ISSUE, WAIT_R, WAIT_W, GUARD.
- IDLE:
  - A port is pending if s_re[i] or s_we[i] is high.
  - If both ports are pending, the port != rr_ptr wins; rr_ptr is the last granted port, 0 after reset.
  - If one port is pending, it wins.
  - On a win: latch the winner into grant, set rr_ptr=grant, latch the winner's addr/wdata/wstrb into m_*. The operation is read if s_re[g] is high, else write; s_re and s_we both high on one port is treated as a read, and the write stays pending. Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Read: m_re=1 for exactly this one cycle, then go to WAIT_R.
  - Write with m_w_busy=0: m_we=1 for one cycle, then go to WAIT_W.
  - Write with m_w_busy=1: hold in ISSUE with m_we=0 until busy clears.
- Latency: request seen in IDLE at cycle t gives the start strobe high at t+1.
- WAIT_R:
  - m_r_success: s_rdata<=m_rdata, s_r_success[grant]<=1, go to GUARD.
  - m_r_timeout: s_r_timeout[grant]<=1, go to GUARD.
  - Success and timeout in the same cycle: success wins.
- WAIT_W:
  - The watchdog increments each cycle.
  - m_w_success: s_w_success[grant]<=1, go to GUARD.
  - Watchdog == WDOG_LIMIT without success: s_w_timeout[grant]<=1, go to GUARD.
  - Success in the same cycle the limit is reached: success wins.
  - The watchdog clears on leaving WAIT_W.
- GUARD:
  - The done pulse is high for exactly this cycle; all requests are ignored.
  - Go to IDLE next cycle.
- Pulses never assert on the non-granted port's bit.
- Completion inputs arriving outside WAIT_R/WAIT_W are ignored.
- s_rdata holds its value until the next read success.

Test Plan:
- Port 0 read only, addr=4'h0; m_r_success 3 cycles after m_re with m_rdata=32'h41 -> m_re one cycle at t+1; s_r_success=2'b01 for one cycle; s_rdata=32'h41; port 1 outputs stay 0.
- Both ports write from reset (port0 wdata=8'h99, port1 wdata=8'haa) -> port 1 is served first (rr_ptr=0), then port 0; m_wdata order is 8'haa, 8'h99; each gets only its own s_w_success bit.
- Port 1 write with m_w_busy high for 5 cycles -> m_we stays 0 for 5 cycles, asserts exactly once after busy falls, then s_w_success=2'b10.
- Port 0 write, m_w_success never asserts, WDOG_LIMIT=8 -> s_w_timeout=2'b01 one cycle, after 8 cycles in WAIT_W; next request is accepted normally.
- Port 0 read with m_r_timeout -> s_r_timeout=2'b01; s_rdata unchanged from the prior value.
- rst low in WAIT_R -> immediately state IDLE and all outputs 0; a late m_r_success after rst rises produces no pulse.

Source files
------------

// File: rtl/axi_io_arbiter.sv
// axi_io_arbiter: round-robin sharing of one request-level AXI master between two requesters,
// with a write watchdog so a stuck B channel cannot hold the port forever.
module axi_io_arbiter #(
  parameter int AXI_ADDRW = 4,
  parameter int AXI_DATAW = 32,
  parameter int WDOG_W = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 s_re,
  input  logic [1:0]                 s_we,
  input  logic [2*AXI_ADDRW-1:0]     s_addr,
  input  logic [2*AXI_DATAW-1:0]     s_wdata,
  input  logic [2*(AXI_DATAW/8)-1:0] s_wstrb,
  output logic [AXI_DATAW-1:0]       s_rdata,
  output logic [1:0]                 s_r_success,
  output logic [1:0]                 s_r_timeout,
  output logic [1:0]                 s_w_success,
  output logic [1:0]                 s_w_timeout,
  output logic                       grant,
  output logic                       busy,
  output logic                       m_re,
  output logic                       m_we,
  output logic [AXI_ADDRW-1:0]       m_araddr,
  output logic [AXI_ADDRW-1:0]       m_awaddr,
  output logic [AXI_DATAW-1:0]       m_wdata,
  output logic [AXI_DATAW/8-1:0]     m_wstrb,
  input  logic [AXI_DATAW-1:0]       m_rdata,
  input  logic                       m_r_success,
  input  logic                       m_r_timeout,
  input  logic                       m_w_success,
  input  logic                       m_w_busy
);
  localparam int SW = AXI_DATAW / 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, WAIT_W, GUARD} state_t;
  state_t state;
  logic [WDOG_W-1:0] wdog;
  logic [1:0] pend, oh;
  logic win;
  logic [AXI_ADDRW-1:0] sel_addr;
  logic [AXI_DATAW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;
  always_comb begin
    pend = s_re | s_we;
    win = &pend ? ~grant : pend[1];
    sel_addr = win ? s_addr[2*AXI_ADDRW-1 -: AXI_ADDRW] : s_addr[AXI_ADDRW-1:0];
    sel_wdata = win ? s_wdata[2*AXI_DATAW-1 -: AXI_DATAW] : s_wdata[AXI_DATAW-1:0];
    sel_wstrb = win ? s_wstrb[2*SW-1 -: SW] : s_wstrb[SW-1:0];
    oh = {grant, ~grant};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 1'b0;
      busy <= 1'b0;
      wdog <= '0;
      m_re <= 1'b0;
      m_we <= 1'b0;
      m_araddr <= '0;
      m_awaddr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      s_rdata <= '0;
      s_r_success <= '0;
      s_r_timeout <= '0;
      s_w_success <= '0;
      s_w_timeout <= '0;
    end else begin
      m_re <= 1'b0;
      m_we <= 1'b0;
      s_r_success <= '0;
      s_r_timeout <= '0;
      s_w_success <= '0;
      s_w_timeout <= '0;
      case (state)
        IDLE: if (|pend) begin
          grant <= win;
          busy <= 1'b1;
          m_araddr <= sel_addr;
          m_awaddr <= sel_addr;
          m_wdata <= sel_wdata;
          m_wstrb <= sel_wstrb;
          m_re <= s_re[win];
          m_we <= ~s_re[win] & ~m_w_busy;
          state <= ISSUE;
        end
        // the strobe is high during ISSUE; a write blocked by m_w_busy retries here
        ISSUE: begin
          if (m_re) state <= WAIT_R;
          else if (m_we) state <= WAIT_W;
          else m_we <= ~m_w_busy;
        end
        WAIT_R: begin
          if (m_r_success) begin
            s_rdata <= m_rdata;
            s_r_success <= oh;
            state <= GUARD;
          end else if (m_r_timeout) begin
            s_r_timeout <= oh;
            state <= GUARD;
          end
        end
        WAIT_W: begin
          if (m_w_success) begin
            s_w_success <= oh;
            wdog <= '0;
            state <= GUARD;
          end else if (wdog + WDOG_W'(1) == WDOG_LIMIT) begin
            s_w_timeout <= oh;
            wdog <= '0;
            state <= GUARD;
          end else wdog <= wdog + WDOG_W'(1);
        end
        GUARD: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
